// File: rtl/l2_pkg.sv
// Shared constants and encodings for the L2 D-cache line responder.
// Line geometry, FSM state encoding and D-cache op encoding.
package l2_pkg;

  localparam int LINE_W   = 512;
  localparam int MEM_W    = 32;
  localparam int BEATS    = LINE_W / MEM_W;
  localparam int BEAT_W   = $clog2(BEATS);
  localparam int OFFSET_W = 6;

  typedef enum logic [2:0] {
    IDLE,
    WR_BEAT,
    RD_ADDR,
    RD_DATA,
    ACK
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

endpackage

// File: rtl/l2_line_buf.sv
// 16 x 32-bit line buffer: parallel line load, per-word write,
// per-word read mux and the full line as a flat vector.
module l2_line_buf
  import l2_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LINE_W-1:0] load_data,
  input  logic              we,
  input  logic [BEAT_W-1:0] widx,
  input  logic [MEM_W-1:0]  wdata,
  input  logic [BEAT_W-1:0] ridx,
  output logic [MEM_W-1:0]  rdata,
  output logic [LINE_W-1:0] line
);

  logic [MEM_W-1:0] mem [BEATS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BEATS; i++)
        mem[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < BEATS; i++)
        mem[i] <= load_data[i*MEM_W +: MEM_W];
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

  for (genvar g = 0; g < BEATS; g++) begin : g_line
    assign line[g*MEM_W +: MEM_W] = mem[g];
  end

endmodule

// File: rtl/l2_dcache_resp.sv
// L2 responder: D-cache line read/write as 16 word beats on a memory port.
// Define L2_RESP_CRIT_WORD_EN to start reads at the requested word.
module l2_dcache_resp
  import l2_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              D_cache_req,
  input  logic              D_cache_req_op,
  input  logic [ADDR_W-1:0] D_cache_req_addr,
  input  logic [LINE_W-1:0] D_cache_wr_data,
  output logic              L2_cache_ack_D_cache,
  output logic [LINE_W-1:0] D_cache_rd_data,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [MEM_W-1:0]  mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [MEM_W-1:0]  mem_rdata
);

  localparam int TAG_W = ADDR_W - OFFSET_W;

  state_e            state, state_n;
  logic [BEAT_W-1:0] beat, idx;
  logic [TAG_W-1:0]  line_addr;
  logic [MEM_W-1:0]  buf_rdata;
  logic              accept, beat_inc;
  logic              buf_load, buf_we;
  logic              is_wr;

  assign is_wr = op_e'(D_cache_req_op) == OP_WRITE;

`ifdef L2_RESP_CRIT_WORD_EN
  logic [BEAT_W-1:0] start;
  logic              unused_addr;

  // Writes always run from word 0; reads begin at the requested word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      start <= '0;
    else if (accept)
      start <= is_wr ? '0 : D_cache_req_addr[OFFSET_W-1:2];
  end

  assign idx = beat + start;
  assign unused_addr = ^D_cache_req_addr[1:0];
`else
  logic unused_addr;

  assign idx = beat;
  assign unused_addr = ^D_cache_req_addr[OFFSET_W-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= IDLE;
      beat                 <= '0;
      line_addr            <= '0;
      L2_cache_ack_D_cache <= 1'b0;
    end else begin
      state                <= state_n;
      L2_cache_ack_D_cache <= state_n == ACK;
      if (accept) begin
        line_addr <= D_cache_req_addr[ADDR_W-1:OFFSET_W];
        beat      <= '0;
      end else if (beat_inc) begin
        beat <= beat + BEAT_W'(1);
      end
    end
  end

  always_comb begin
    state_n   = state;
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    accept    = 1'b0;
    beat_inc  = 1'b0;
    buf_load  = 1'b0;
    buf_we    = 1'b0;
    unique case (state)
      IDLE: begin
        if (D_cache_req) begin
          accept   = 1'b1;
          buf_load = is_wr;
          state_n  = is_wr ? WR_BEAT : RD_ADDR;
        end
      end
      WR_BEAT: begin
        mem_valid = 1'b1;
        mem_we    = 1'b1;
        if (mem_ready) begin
          beat_inc = 1'b1;
          if (beat == BEAT_W'(BEATS - 1))
            state_n = ACK;
        end
      end
      RD_ADDR: begin
        mem_valid = 1'b1;
        if (mem_ready)
          state_n = RD_DATA;
      end
      RD_DATA: begin
        if (mem_rvalid) begin
          buf_we   = 1'b1;
          beat_inc = 1'b1;
          state_n  = (beat == BEAT_W'(BEATS - 1)) ? ACK : RD_ADDR;
        end
      end
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign mem_addr  = {line_addr, idx, 2'b00};
  assign mem_wdata = mem_we ? buf_rdata : '0;

  l2_line_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .load_data (D_cache_wr_data),
    .we        (buf_we),
    .widx      (idx),
    .wdata     (mem_rdata),
    .ridx      (idx),
    .rdata     (buf_rdata),
    .line      (D_cache_rd_data)
  );

endmodule
